// File: rtl/clk_ratio_monitor_pkg.sv
// Shared state encoding and counter constants for clk_ratio_monitor and its bench.
package clk_ratio_monitor_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TRACK   = 2'd2,
    LOCKED  = 2'd3
  } mon_state_t;

endpackage

// File: rtl/clk_edge_detect.sv
// Samples a slow level in the fast domain and registers one-cycle rise/fall strobes.
// CLK_RATIO_MON_SYNC_EN adds a 2-flop synchronizer ahead of the sample register.
module clk_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise_evt,
  output logic fall_evt,
  output logic rise_stb,
  output logic fall_stb
);

  logic src;
  logic prev;

`ifdef CLK_RATIO_MON_SYNC_EN
  logic sync1;
  logic sync2;

  // NOTE: non-blocking assignments make sync2 take sync1's old value, giving two real stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign src = sync2;
`else
  assign src = raw;
`endif

  // Sample resets to 0, so an input already high at release shows up as a rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level    <= 1'b0;
      prev     <= 1'b0;
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
    end else begin
      level    <= src;
      prev     <= level;
      rise_stb <= rise_evt;
      fall_stb <= fall_evt;
    end
  end

  assign rise_evt = level & ~prev;
  assign fall_evt = ~level & prev;

endmodule

// File: rtl/clk_ratio_monitor.sv
// Measures a divided clock's period/high time in fast cycles and tracks lock to EXP_PERIOD.
// Optional CLK_RATIO_MON_SYNC_EN (in clk_edge_detect) adds two cycles of input synchronization.
module clk_ratio_monitor
  import clk_ratio_monitor_pkg::*;
#(
  parameter int EXP_PERIOD = 8,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = clk_ratio_monitor_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             slow_clk_in,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             locked,
  output logic             err
);

  localparam int MC_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] SAT     = '1;
  localparam logic [CNT_W-1:0] SAT_PRE = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] EXP     = CNT_W'(EXP_PERIOD);
  localparam logic [MC_W-1:0]  MC_LOCK = MC_W'(LOCK_COUNT);
  localparam logic [MC_W-1:0]  MC_ONE  = MC_W'(1);

  logic             level;
  logic             rise_evt;
  logic             fall_evt;
  logic             match;
  logic [CNT_W-1:0] pc;
  logic [CNT_W-1:0] hc;
  logic [MC_W-1:0]  mc;
  logic [MC_W-1:0]  mc_inc;
  mon_state_t       state;

  clk_edge_detect u_edge (
    .clk      (clk),
    .reset    (reset),
    .raw      (slow_clk_in),
    .level    (level),
    .rise_evt (rise_evt),
    .fall_evt (fall_evt),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  assign match  = (pc == EXP);
  assign mc_inc = mc + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= '0;
      hc        <= '0;
      mc        <= '0;
      period    <= '0;
      high_time <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      if (level && hc != SAT) hc <= hc + 1'b1;
      if (fall_evt) high_time <= hc;

      if (rise_evt) begin
        // A rise coinciding with saturation restarts the counters, so no timeout fires.
        pc <= CNT_W'(1);
        hc <= CNT_W'(1);
        case (state)
          IDLE: state <= MEASURE;
          MEASURE: begin
            period <= pc;
            mc     <= match ? MC_ONE : '0;
            if (match && MC_ONE == MC_LOCK) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end else begin
              state <= TRACK;
            end
          end
          TRACK: begin
            period <= pc;
            if (!match) begin
              mc <= '0;
            end else if (mc_inc == MC_LOCK) begin
              mc     <= mc_inc;
              state  <= LOCKED;
              locked <= 1'b1;
            end else begin
              mc <= mc_inc;
            end
          end
          LOCKED: begin
            period <= pc;
            if (!match) begin
              err    <= 1'b1;
              locked <= 1'b0;
              mc     <= '0;
              state  <= TRACK;
            end
          end
          default: state <= IDLE;
        endcase
      end else begin
        if (pc != SAT) pc <= pc + 1'b1;
        // Fires only on the step into saturation, so a stuck input yields a single err pulse.
        if (pc == SAT_PRE) begin
          err    <= 1'b1;
          locked <= 1'b0;
          mc     <= '0;
          state  <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Scoreboard bench for clk_ratio_monitor: directed slow-clock waveforms with hand-computed responses.
module tb_clk_ratio_monitor;
  import clk_ratio_monitor_pkg::*;

`ifdef CLK_RATIO_MON_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  typedef enum logic [1:0] {EV_RISE, EV_FALL, EV_TOUT} ev_t;
  typedef struct {
    ev_t        kind;
    int         cyc;
    logic [7:0] period;
    logic [7:0] high_time;
    logic       locked;
    logic       err;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       slow_clk_in;
  logic       rise_stb;
  logic       fall_stb;
  logic       locked;
  logic       err;
  logic [7:0] period;
  logic [7:0] high_time;

  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t q[$];
  exp_t mon_e;
  ev_t  mon_k;

  clk_ratio_monitor #(
    .EXP_PERIOD (8),
    .LOCK_COUNT (4),
    .CNT_W      (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .slow_clk_in (slow_clk_in),
    .rise_stb    (rise_stb),
    .fall_stb    (fall_stb),
    .period      (period),
    .high_time   (high_time),
    .locked      (locked),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input ev_t k, input int c, input logic [7:0] p, input logic [7:0] h,
                      input logic l, input logic e);
    exp_t x;
    x.kind = k; x.cyc = c; x.period = p; x.high_time = h; x.locked = l; x.err = e;
    q.push_back(x);
  endtask

  // One slow period: high for h cycles, low for p-h. rp/rl/re are the expected
  // period, locked and err seen at this period's rising strobe.
  task automatic seg(input int h, input int p, input logic [7:0] rp, input logic rl, input logic re);
    tick();
    slow_clk_in = 1'b1;
    push(EV_RISE, cyc + LAT, rp, 8'h00, rl, re);
    repeat (h - 1) tick();
    tick();
    slow_clk_in = 1'b0;
    push(EV_FALL, cyc + LAT, rp, 8'(h), rl, 1'b0);
    repeat (p - h - 1) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rise_stb"},  rise_stb,  0);
    check({tag, "_fall_stb"},  fall_stb,  0);
    check({tag, "_period"},    period,    0);
    check({tag, "_high_time"}, high_time, 0);
    check({tag, "_locked"},    locked,    0);
    check({tag, "_err"},       err,       0);
  endtask

  always @(negedge clk) begin
    if (!reset && (rise_stb || fall_stb || err)) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: rise=%b fall=%b err=%b at cycle %0d, expected no event",
                 rise_stb, fall_stb, err, cyc);
      end else begin
        mon_e = q.pop_front();
        mon_k = rise_stb ? EV_RISE : (fall_stb ? EV_FALL : EV_TOUT);
        check({mon_e.kind.name(), "_kind"},   mon_k,  mon_e.kind);
        check({mon_e.kind.name(), "_cycle"},  cyc,    mon_e.cyc);
        check({mon_e.kind.name(), "_period"}, period, mon_e.period);
        check({mon_e.kind.name(), "_locked"}, locked, mon_e.locked);
        check({mon_e.kind.name(), "_err"},    err,    mon_e.err);
        if (mon_e.kind == EV_FALL) check("EV_FALL_high_time", high_time, mon_e.high_time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    slow_clk_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Clean locking at period 8, high 4: lock on the 5th rise.
    seg(4, 8, 8'd0, 1'b0, 1'b0);
    seg(4, 8, 8'd8, 1'b0, 1'b0);
    seg(4, 8, 8'd8, 1'b0, 1'b0);
    seg(4, 8, 8'd8, 1'b0, 1'b0);
    seg(4, 8, 8'd8, 1'b1, 1'b0);
    seg(4, 8, 8'd8, 1'b1, 1'b0);

    // One period of 10 while locked, then relock on the 4th good rise.
    seg(4, 10, 8'd8,  1'b1, 1'b0);
    seg(4, 8,  8'd10, 1'b0, 1'b1);
    seg(4, 8,  8'd8,  1'b0, 1'b0);
    seg(4, 8,  8'd8,  1'b0, 1'b0);
    seg(4, 8,  8'd8,  1'b0, 1'b0);
    seg(4, 8,  8'd8,  1'b1, 1'b0);

    // Duty cycle 3/8 keeps lock.
    seg(3, 8, 8'd8, 1'b1, 1'b0);
    seg(3, 8, 8'd8, 1'b1, 1'b0);

    // Stuck high: pc climbs 1..255 after the rise strobe, timeout on the 254th step.
    tick();
    slow_clk_in = 1'b1;
    push(EV_RISE, cyc + LAT, 8'd8, 8'h00, 1'b1, 1'b0);
    push(EV_TOUT, cyc + LAT + 254, 8'd8, 8'h00, 1'b0, 1'b1);
    repeat (299) tick();
    tick();
    slow_clk_in = 1'b0;
    push(EV_FALL, cyc + LAT, 8'd8, CNT_SAT, 1'b0, 1'b0);
    repeat (3) tick();

    // Resume: restart from IDLE, lock again on the 5th rise.
    seg(4, 8, 8'd8, 1'b0, 1'b0);
    seg(4, 8, 8'd8, 1'b0, 1'b0);
    seg(4, 8, 8'd8, 1'b0, 1'b0);
    seg(4, 8, 8'd8, 1'b0, 1'b0);
    seg(4, 8, 8'd8, 1'b1, 1'b0);

    // Reset for 3 cycles while locked.
    repeat (6) tick();
    check("pre_reset_queue_empty", q.size(), 0);
    check("pre_reset_locked", locked, 1);
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    repeat (3) tick();
    check_all_zero("held_reset");
    reset = 1'b0;

    // After release the first rise leaves period at 0.
    seg(4, 8, 8'd0, 1'b0, 1'b0);
    seg(4, 8, 8'd8, 1'b0, 1'b0);
    seg(4, 8, 8'd8, 1'b0, 1'b0);
    seg(4, 8, 8'd8, 1'b0, 1'b0);
    seg(4, 8, 8'd8, 1'b1, 1'b0);

    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
